// File: rtl/conv_window_feeder.sv
// Walks a feature map in SRAM and emits every valid-mode 3x3 window in raster order,
// re-reading only the entering column on each horizontal step.
module conv_window_feeder #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [71:0]       w_in,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              o_valid,
  output logic [71:0]       o_tensor,
  output logic [71:0]       o_weight,
  output logic [ADDR_W-1:0] o_addr,
  output logic              busy,
  output logic              done
);

  localparam int R = IMG_H - 2;
  localparam int C = IMG_W - 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_SLIDE = 3'd2,
    S_WAIT  = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   r_q, r_d, c_q, c_d;
  logic [1:0]          rd_row_q, rd_row_d, rd_col_q, rd_col_d;
  logic [1:0]          cap_row_q, cap_row_d;
  logic                rd_vld_q, rd_vld_d;
  logic [15:0]         colbuf_q, colbuf_d;
  logic [71:0]         win_q, win_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                o_valid_q, o_valid_d;
  logic [71:0]         o_tensor_q, o_tensor_d;
  logic [71:0]         o_weight_q, o_weight_d;
  logic [ADDR_W-1:0]   o_addr_q, o_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] y,
                                                 input logic [ADDR_W-1:0] x);
    return y * ADDR_W'(IMG_W) + x;
  endfunction

  // Drop column 0, move columns 1,2 left, and place the completed column in slot 2.
  function automatic logic [71:0] shift_in(input logic [71:0] win,
                                           input logic [15:0] colbuf,
                                           input logic [7:0]  rdata);
    logic [71:0] w;
    w = win;
    for (int row = 0; row < 3; row++) begin
      w[row*24 +: 8]     = win[row*24 + 8 +: 8];
      w[row*24 + 8 +: 8] = win[row*24 + 16 +: 8];
    end
    w[16 +: 8] = colbuf[7:0];
    w[40 +: 8] = colbuf[15:8];
    w[64 +: 8] = rdata;
    return w;
  endfunction

  // Next-state, read sequencing, window capture and output register updates.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    rd_row_d    = rd_row_q;
    rd_col_d    = rd_col_q;
    cap_row_d   = cap_row_q;
    rd_vld_d    = mem_rd_en_q;
    colbuf_d    = colbuf_q;
    win_d       = win_q;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    o_valid_d   = 1'b0;
    o_tensor_d  = o_tensor_q;
    o_weight_d  = o_weight_q;
    o_addr_d    = o_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (rd_vld_q) begin
      if (cap_row_q == 2'd2) begin
        win_d     = shift_in(win_q, colbuf_q, mem_rdata);
        cap_row_d = 2'd0;
      end else begin
        if (cap_row_q == 2'd0) begin
          colbuf_d[7:0] = mem_rdata;
        end else begin
          colbuf_d[15:8] = mem_rdata;
        end
        cap_row_d = cap_row_q + 2'd1;
      end
    end else begin
      cap_row_d = cap_row_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FILL;
          o_weight_d  = w_in;
          r_d         = '0;
          c_d         = '0;
          busy_d      = 1'b1;
          rd_row_d    = 2'd0;
          rd_col_d    = 2'd0;
          cap_row_d   = 2'd0;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = pix_addr('0, '0);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (rd_row_q == 2'd2 && rd_col_q == 2'd2) begin
          state_d = S_WAIT;
        end else begin
          if (rd_row_q == 2'd2) begin
            rd_row_d = 2'd0;
            rd_col_d = rd_col_q + 2'd1;
          end else begin
            rd_row_d = rd_row_q + 2'd1;
          end
          mem_rd_en_d = 1'b1;
          mem_addr_d  = pix_addr(r_q + ADDR_W'(rd_row_d), c_q + ADDR_W'(rd_col_d));
        end
      end
      S_SLIDE: begin
        if (rd_row_q == 2'd2) begin
          state_d = S_WAIT;
        end else begin
          rd_row_d    = rd_row_q + 2'd1;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = pix_addr(r_q + ADDR_W'(rd_row_d), c_q + ADDR_W'(2));
        end
      end
      S_WAIT: begin
        // The last pixel lands this cycle, so publish the window including it.
        state_d    = S_EMIT;
        o_valid_d  = 1'b1;
        o_tensor_d = win_d;
        o_addr_d   = r_q * ADDR_W'(C) + c_q;
      end
      S_EMIT: begin
        if (c_q < ADDR_W'(C - 1)) begin
          state_d     = S_SLIDE;
          c_d         = c_q + ADDR_W'(1);
          rd_row_d    = 2'd0;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = pix_addr(r_q, c_q + ADDR_W'(3));
        end else if (r_q < ADDR_W'(R - 1)) begin
          state_d     = S_FILL;
          c_d         = '0;
          r_d         = r_q + ADDR_W'(1);
          rd_row_d    = 2'd0;
          rd_col_d    = 2'd0;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = pix_addr(r_q + ADDR_W'(1), '0);
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset also drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      c_q         <= '0;
      rd_row_q    <= 2'd0;
      rd_col_q    <= 2'd0;
      cap_row_q   <= 2'd0;
      rd_vld_q    <= 1'b0;
      colbuf_q    <= 16'd0;
      win_q       <= 72'd0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      o_valid_q   <= 1'b0;
      o_tensor_q  <= 72'd0;
      o_weight_q  <= 72'd0;
      o_addr_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      cap_row_q   <= cap_row_d;
      rd_vld_q    <= rd_vld_d;
      colbuf_q    <= colbuf_d;
      win_q       <= win_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      o_valid_q   <= o_valid_d;
      o_tensor_q  <= o_tensor_d;
      o_weight_q  <= o_weight_d;
      o_addr_q    <= o_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign o_valid   = o_valid_q;
  assign o_tensor  = o_tensor_q;
  assign o_weight  = o_weight_q;
  assign o_addr    = o_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench: 4x4, 16x16 and 3x3 instances share inputs; each task checks one scenario.
module tb_conv_window_feeder;

  localparam int MAXC = 1100;
  localparam logic [71:0] W1 = 72'h090807060504030201;
  localparam logic [71:0] W2 = 72'hA5C3E1F00F1E2D3C4B;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [71:0] w_in;
  int          sel;
  int          total = 0;
  int          bad   = 0;

  logic        rd_en_v [3];
  logic [13:0] addr_v  [3];
  logic [7:0]  rdata_v [3];
  logic        valid_v [3];
  logic [71:0] tensor_v[3];
  logic [71:0] weight_v[3];
  logic [13:0] oaddr_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];

  logic        m_rd_en, m_valid, m_busy, m_done;
  logic [13:0] m_addr, m_oaddr;
  logic [71:0] m_tensor, m_weight;

  logic        s_rd_en [MAXC];
  logic [13:0] s_addr  [MAXC];
  logic        s_valid [MAXC];
  logic [71:0] s_tensor[MAXC];
  logic [71:0] s_weight[MAXC];
  logic [13:0] s_oaddr [MAXC];
  logic        s_busy  [MAXC];
  logic        s_done  [MAXC];
  logic [183:0] s_all  [MAXC];

  always #5 clk = ~clk;

  conv_window_feeder #(.IMG_W(4), .IMG_H(4), .ADDR_W(14)) u4 (
    .clk(clk), .rst(rst), .start(start), .w_in(w_in),
    .mem_rd_en(rd_en_v[0]), .mem_addr(addr_v[0]), .mem_rdata(rdata_v[0]),
    .o_valid(valid_v[0]), .o_tensor(tensor_v[0]), .o_weight(weight_v[0]),
    .o_addr(oaddr_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  conv_window_feeder u16 (
    .clk(clk), .rst(rst), .start(start), .w_in(w_in),
    .mem_rd_en(rd_en_v[1]), .mem_addr(addr_v[1]), .mem_rdata(rdata_v[1]),
    .o_valid(valid_v[1]), .o_tensor(tensor_v[1]), .o_weight(weight_v[1]),
    .o_addr(oaddr_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  conv_window_feeder #(.IMG_W(3), .IMG_H(3), .ADDR_W(14)) u3 (
    .clk(clk), .rst(rst), .start(start), .w_in(w_in),
    .mem_rd_en(rd_en_v[2]), .mem_addr(addr_v[2]), .mem_rdata(rdata_v[2]),
    .o_valid(valid_v[2]), .o_tensor(tensor_v[2]), .o_weight(weight_v[2]),
    .o_addr(oaddr_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  // SRAM models: pixel value is the low byte of its address, one-cycle latency.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_en_v[i]) rdata_v[i] <= addr_v[i][7:0];
    end
  end

  assign m_rd_en  = rd_en_v[sel];
  assign m_addr   = addr_v[sel];
  assign m_valid  = valid_v[sel];
  assign m_tensor = tensor_v[sel];
  assign m_weight = weight_v[sel];
  assign m_oaddr  = oaddr_v[sel];
  assign m_busy   = busy_v[sel];
  assign m_done   = done_v[sel];

  function automatic logic [71:0] model_win(input int w, input int r, input int c);
    logic [71:0] t;
    t = 72'd0;
    for (int row = 0; row < 3; row++)
      for (int col = 0; col < 3; col++)
        t[(row*3 + col)*8 +: 8] = 8'((r + row)*w + c + col);
    return t;
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  // Start sampled at the next edge (cycle 0); returns in cycle 1.
  task automatic kick(input logic [71:0] w);
    @(negedge clk); start = 1'b1; w_in = w;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic capture(input int n, input int rst_cyc, input int st_cyc, input logic [71:0] st_w);
    for (int cyc = 1; cyc <= n; cyc++) begin
      s_rd_en[cyc]  = m_rd_en;  s_addr[cyc]   = m_addr;
      s_valid[cyc]  = m_valid;  s_tensor[cyc] = m_tensor;
      s_weight[cyc] = m_weight; s_oaddr[cyc]  = m_oaddr;
      s_busy[cyc]   = m_busy;   s_done[cyc]   = m_done;
      s_all[cyc]    = {m_rd_en, m_addr, m_valid, m_tensor, m_weight, m_oaddr, m_busy, m_done};
      rst   = (cyc == rst_cyc);
      start = (cyc == st_cyc);
      if (cyc == st_cyc) w_in = st_w;
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    logic [183:0] v;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sel = i; #1;
      v = {m_rd_en, m_addr, m_valid, m_tensor, m_weight, m_oaddr, m_busy, m_done};
      if (v !== 184'd0) begin bad++; $display("FAIL reset_outputs inst=%0d got=%h want=0", i, v); end
      total++;
    end
  endtask

  task automatic test_frame_4x4();
    logic [13:0] rd_tab[12] = '{14'd0, 14'd4, 14'd8, 14'd1, 14'd5, 14'd9, 14'd2, 14'd6, 14'd10, 14'd3, 14'd7, 14'd11};
    int          v_tab[4]   = '{11, 16, 27, 32};
    logic [71:0] t_tab[4]   = '{72'h0A0908060504020100, 72'h0B0A09070605030201,
                                72'h0E0D0C0A0908060504, 72'h0F0E0D0B0A09070605};
    int nrd = 0;
    int nv  = 0;
    logic ev, erd;
    do_reset(); sel = 0;
    kick(W1);
    capture(40, 0, 0, 72'd0);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      erd = (cyc <= 9) || (cyc >= 12 && cyc <= 14) || (cyc >= 17 && cyc <= 25) || (cyc >= 28 && cyc <= 30);
      if (s_rd_en[cyc] !== erd) begin bad++; $display("FAIL f4_rd_en cyc=%0d got=%b want=%b", cyc, s_rd_en[cyc], erd); end
      total++;
      if (s_rd_en[cyc] === 1'b1 && nrd < 12) begin
        if (s_addr[cyc] !== rd_tab[nrd]) begin bad++; $display("FAIL f4_rd_addr n=%0d got=%0d want=%0d", nrd, s_addr[cyc], rd_tab[nrd]); end
        total++;
        nrd++;
      end
      ev = (nv < 4) && (cyc == v_tab[nv]);
      if (s_valid[cyc] !== ev) begin bad++; $display("FAIL f4_valid cyc=%0d got=%b want=%b", cyc, s_valid[cyc], ev); end
      total++;
      if (ev) begin
        if (s_tensor[cyc] !== t_tab[nv]) begin bad++; $display("FAIL f4_tensor n=%0d got=%h want=%h", nv, s_tensor[cyc], t_tab[nv]); end
        if (s_oaddr[cyc] !== 14'(nv)) begin bad++; $display("FAIL f4_oaddr n=%0d got=%0d want=%0d", nv, s_oaddr[cyc], nv); end
        total += 2;
        nv++;
      end
      if (s_done[cyc] !== (cyc == 33)) begin bad++; $display("FAIL f4_done cyc=%0d got=%b", cyc, s_done[cyc]); end
      if (s_busy[cyc] !== (cyc <= 33)) begin bad++; $display("FAIL f4_busy cyc=%0d got=%b", cyc, s_busy[cyc]); end
      if (s_weight[cyc] !== W1) begin bad++; $display("FAIL f4_weight cyc=%0d got=%h want=%h", cyc, s_weight[cyc], W1); end
      total += 3;
    end
  endtask

  task automatic test_frame_16();
    int nv = 0;
    int ndone = 0;
    int busy_low = 0;
    int consec = 0;
    int ecyc;
    do_reset(); sel = 1;
    kick(W1);
    capture(1070, 0, 0, 72'd0);
    for (int cyc = 1; cyc <= 1070; cyc++) begin
      if (cyc <= 1065 && s_busy[cyc] !== 1'b1) busy_low++;
      if (cyc > 1 && s_valid[cyc] === 1'b1 && s_valid[cyc-1] === 1'b1) consec++;
      if (s_done[cyc] === 1'b1) begin
        ndone++;
        if (cyc != 1065) begin bad++; $display("FAIL f16_done_cyc got=%0d want=1065", cyc); end
        total++;
      end
      if (s_valid[cyc] === 1'b1) begin
        ecyc = (nv / 14)*76 + 11 + 5*(nv % 14);
        if (cyc != ecyc) begin bad++; $display("FAIL f16_valid_cyc n=%0d got=%0d want=%0d", nv, cyc, ecyc); end
        if (s_oaddr[cyc] !== 14'(nv)) begin bad++; $display("FAIL f16_oaddr n=%0d got=%0d want=%0d", nv, s_oaddr[cyc], nv); end
        if (s_tensor[cyc] !== model_win(16, nv / 14, nv % 14)) begin
          bad++; $display("FAIL f16_tensor n=%0d got=%h want=%h", nv, s_tensor[cyc], model_win(16, nv / 14, nv % 14));
        end
        total += 3;
        nv++;
      end
    end
    if (nv != 196) begin bad++; $display("FAIL f16_count got=%0d want=196", nv); end
    if (ndone != 1) begin bad++; $display("FAIL f16_done_count got=%0d want=1", ndone); end
    if (s_valid[1064] !== 1'b1) begin bad++; $display("FAIL f16_last_valid got=%b want=1", s_valid[1064]); end
    if (busy_low != 0) begin bad++; $display("FAIL f16_busy_gap got=%0d want=0", busy_low); end
    if (s_busy[1066] !== 1'b0) begin bad++; $display("FAIL f16_busy_end got=%b want=0", s_busy[1066]); end
    if (consec != 0) begin bad++; $display("FAIL f16_consec_valid got=%0d want=0", consec); end
    total += 6;
  endtask

  task automatic test_start_ignored();
    int          v_tab[4] = '{11, 16, 27, 32};
    logic [71:0] t_tab[4] = '{72'h0A0908060504020100, 72'h0B0A09070605030201,
                              72'h0E0D0C0A0908060504, 72'h0F0E0D0B0A09070605};
    int nv = 0;
    logic ev;
    do_reset(); sel = 0;
    kick(W1);
    capture(40, 0, 20, W2);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      ev = (nv < 4) && (cyc == v_tab[nv]);
      if (s_valid[cyc] !== ev) begin bad++; $display("FAIL ign_valid cyc=%0d got=%b want=%b", cyc, s_valid[cyc], ev); end
      if (s_weight[cyc] !== W1) begin bad++; $display("FAIL ign_weight cyc=%0d got=%h want=%h", cyc, s_weight[cyc], W1); end
      if (s_done[cyc] !== (cyc == 33)) begin bad++; $display("FAIL ign_done cyc=%0d got=%b", cyc, s_done[cyc]); end
      total += 3;
      if (ev) begin
        if (s_tensor[cyc] !== t_tab[nv]) begin bad++; $display("FAIL ign_tensor n=%0d got=%h want=%h", nv, s_tensor[cyc], t_tab[nv]); end
        total++;
        nv++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int late = 0;
    do_reset(); sel = 0;
    kick(W1);
    capture(20, 14, 0, 72'd0);
    if (s_valid[11] !== 1'b1 || s_tensor[11] !== 72'h0A0908060504020100) begin
      bad++; $display("FAIL rm_first_win got=%b/%h want=1/0a0908060504020100", s_valid[11], s_tensor[11]);
    end
    if (s_all[14] === 184'd0) begin bad++; $display("FAIL rm_pre_reset_active got=0 want=nonzero"); end
    if (s_all[15] !== 184'd0) begin bad++; $display("FAIL rm_zero_after_rst got=%h want=0", s_all[15]); end
    total += 3;
    for (int cyc = 15; cyc <= 20; cyc++)
      if (s_valid[cyc] !== 1'b0 || s_rd_en[cyc] !== 1'b0 || s_busy[cyc] !== 1'b0) late++;
    if (late != 0) begin bad++; $display("FAIL rm_idle_after_rst got=%0d active cycles want=0", late); end
    total++;
    kick(W1);
    capture(20, 0, 0, 72'd0);
    if (s_rd_en[1] !== 1'b1 || s_addr[1] !== 14'd0) begin bad++; $display("FAIL rm_restart_addr got=%b/%0d want=1/0", s_rd_en[1], s_addr[1]); end
    if (s_tensor[11] !== 72'h0A0908060504020100) begin bad++; $display("FAIL rm_restart_w0 got=%h want=0a0908060504020100", s_tensor[11]); end
    if (s_valid[16] !== 1'b1 || s_tensor[16] !== 72'h0B0A09070605030201 || s_oaddr[16] !== 14'd1) begin
      bad++; $display("FAIL rm_restart_w1 got=%b/%h/%0d want=1/0b0a09070605030201/1", s_valid[16], s_tensor[16], s_oaddr[16]);
    end
    total += 3;
  endtask

  task automatic test_single_3x3();
    logic [13:0] rd_tab[9] = '{14'd0, 14'd3, 14'd6, 14'd1, 14'd4, 14'd7, 14'd2, 14'd5, 14'd8};
    do_reset(); sel = 2;
    kick(W1);
    capture(15, 0, 0, 72'd0);
    for (int cyc = 1; cyc <= 15; cyc++) begin
      if (s_rd_en[cyc] !== (cyc <= 9)) begin bad++; $display("FAIL s3_rd_en cyc=%0d got=%b", cyc, s_rd_en[cyc]); end
      if (s_valid[cyc] !== (cyc == 11)) begin bad++; $display("FAIL s3_valid cyc=%0d got=%b", cyc, s_valid[cyc]); end
      if (s_done[cyc] !== (cyc == 12)) begin bad++; $display("FAIL s3_done cyc=%0d got=%b", cyc, s_done[cyc]); end
      if (s_busy[cyc] !== (cyc <= 12)) begin bad++; $display("FAIL s3_busy cyc=%0d got=%b", cyc, s_busy[cyc]); end
      total += 4;
      if (cyc <= 9) begin
        if (s_addr[cyc] !== rd_tab[cyc-1]) begin bad++; $display("FAIL s3_rd_addr cyc=%0d got=%0d want=%0d", cyc, s_addr[cyc], rd_tab[cyc-1]); end
        total++;
      end
    end
    if (s_tensor[11] !== 72'h080706050403020100) begin bad++; $display("FAIL s3_tensor got=%h want=080706050403020100", s_tensor[11]); end
    if (s_oaddr[11] !== 14'd0) begin bad++; $display("FAIL s3_oaddr got=%0d want=0", s_oaddr[11]); end
    total += 2;
  endtask

  task automatic test_start_rst_together();
    logic [73:0] v;
    do_reset();
    @(negedge clk); rst = 1'b1; start = 1'b1; w_in = W2;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        v = {rd_en_v[i], busy_v[i], weight_v[i]};
        if (v !== 74'd0) begin bad++; $display("FAIL sr_together inst=%0d cyc=%0d got=%h want=0", i, cyc, v); end
        total++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; w_in = 72'd0; sel = 0;
    test_reset();
    test_frame_4x4();
    test_frame_16();
    test_start_ignored();
    test_reset_mid();
    test_single_3x3();
    test_start_rst_together();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
